univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
Universal shift register built from edge-triggered D flip-flop cells. It is the stage directly downstream of the single D-FF: it consumes per-bit D-FF storage and adds mode-selected next-state logic. Each edge performs one of four operations: hold, shift right, shift left or parallel load. Serial outputs allow cascading and ring/Johnson counters.

Parameters:
WIDTH, 4, number of register bits (≥2).

Ports:
Cp  input  1  clock; all state changes on rising edge
nReset  input  1  asynchronous active-low reset; clears all bits
S  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load
SR_in  input  1  serial data entering at MSB during shift right
SL_in  input  1  serial data entering at LSB during shift left
P  input  WIDTH  parallel load data
Q  output  WIDTH  register contents
SO_R  output  1  serial out for right shift = Q[0]
SO_L  output  1  serial out for left shift = Q[WIDTH-1]

Behaviour:
- One clock (Cp). Reset is asynchronous and active-low (nReset).
- nReset low: Q = 0 immediately, without waiting for Cp. SO_R = SO_L = 0. Cp edges are ignored while nReset is low.
- First rising Cp edge after nReset rises acts normally.
- Reset asserted mid-operation (any mode) discards contents; no partial shift completes.
- Next state is sampled on the rising Cp edge from S, SR_in, SL_in, P and current Q. Latency is 1 edge.
  - S=00: Q unchanged.
  - S=01: Q[WIDTH-1] <= SR_in; Q[i] <= Q[i+1] for i < WIDTH-1. The old Q[0] is lost and was visible on SO_R before the edge.
  - S=10: Q[0] <= SL_in; Q[i] <= Q[i-1] for i > 0. The old Q[WIDTH-1] was visible on SO_L before the edge.
  - S=11: Q <= P.
- Input changes between edges (S, P, serial inputs, including mode changes) have no effect on Q.
- The falling edge of Cp has no effect.
- SO_R and SO_L are combinational from Q and carry no extra latency.
- Feedback wiring is legal and well-defined because each bit's next state depends only on pre-edge values:
  - SR_in tied to SO_R gives a rotate right.
  - SR_in tied to ~SO_R gives a Johnson counter.
- No X-propagation from an unused serial input: in each mode only the listed inputs matter.

Decomposition:
- Shared package: mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
- Sub-module dff_clr: 1-bit rising-edge D-FF with asynchronous active-low clear (ports Cp, nReset, D, Q). Instantiated WIDTH times via generate.
- Top level: per-bit 4:1 next-state mux selected by S. Boundary bits take SR_in / SL_in in place of a missing neighbour.

Test Plan:
1. Reset: Q=1010 via load, then pull nReset low between edges → Q=0000 at once, SO_R=SO_L=0. Hold nReset low across 2 Cp edges with S=11, P=1111 → Q stays 0000.
2. Load: nReset=1, S=11, P=1011, one edge → Q=1011, SO_R=1, SO_L=1. Change P to 0000 between edges → Q unchanged until the next edge.
3. Shift right from 1011, S=01, SR_in=0, 4 edges → Q=0101, 0010, 0001, 0000. SO_R before each edge = 1, 1, 0, 1.
4. Shift left from 0000, S=10, SL_in=1, 4 edges → Q=0001, 0011, 0111, 1111. SO_L ends at 1.
5. Hold: Q=1011, S=00, toggle P, SR_in and SL_in across 3 edges → Q remains 1011.
6. Rotate/Johnson:
   - Load 1000, SR_in tied to SO_R, S=01, 4 edges → 0100, 0010, 0001, 1000.
   - Then reset, SR_in=~SO_R, 8 edges → 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Mode encoding shared by the universal shift register, its bus interface and benches.
package univ_shift_reg_pkg;
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;
endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; the register itself sits on the slave side.
interface univ_shift_reg_if #(
  parameter int WIDTH = 4
);
  import univ_shift_reg_pkg::*;

  mode_t            S;
  logic             SR_in;
  logic             SL_in;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] Q;
  logic             SO_R;
  logic             SO_L;

  modport master (output S, SR_in, SL_in, P, input Q, SO_R, SO_L);
  modport slave  (input S, SR_in, SL_in, P, output Q, SO_R, SO_L);
endinterface

// File: rtl/univ_shift_reg_dff_clr.sv
// Single storage bit: rising-edge D flip-flop with asynchronous active-low clear.
module dff_clr (
  input  logic Cp,
  input  logic nReset,
  input  logic D,
  output logic Q
);
  always_ff @(posedge Cp or negedge nReset) begin
    if (!nReset) Q <= 1'b0;
    else         Q <= D;
  end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, one dff_clr per bit.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Cp,
  input  logic             nReset,
  univ_shift_reg_if.slave  bus
);
  logic [WIDTH-1:0] qInt;

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    logic upperNbr;
    logic lowerNbr;
    logic d;

    // Boundary bits take the serial input in place of the missing neighbour.
    if (i == WIDTH - 1) begin : gMsb
      assign upperNbr = bus.SR_in;
    end else begin : gUpper
      assign upperNbr = qInt[i+1];
    end

    if (i == 0) begin : gLsb
      assign lowerNbr = bus.SL_in;
    end else begin : gLower
      assign lowerNbr = qInt[i-1];
    end

    always_comb begin
      d = qInt[i];
      case (bus.S)
        MODE_HOLD: d = qInt[i];
        MODE_SHR:  d = upperNbr;
        MODE_SHL:  d = lowerNbr;
        MODE_LOAD: d = bus.P[i];
        default:   d = qInt[i];
      endcase
    end

    dff_clr uBit (
      .Cp     (Cp),
      .nReset (nReset),
      .D      (d),
      .Q      (qInt[i])
    );
  end

  assign bus.Q    = qInt;
  assign bus.SO_R = qInt[0];
  assign bus.SO_L = qInt[WIDTH-1];
endmodule
